// File: rtl/flatten_stream_reader_if.sv
// Bundles the upstream result-memory read port and the downstream byte stream
// so the reader and its neighbours connect through a single port each.
interface flatten_stream_reader_if;
  logic        up_start;
  logic        up_done;
  logic [31:0] up_read_addr;
  logic [7:0]  up_read_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;

  modport master (
    output up_start, up_read_addr, m_valid, m_data, m_last,
    input  up_done, up_read_data, m_ready
  );

  modport slave (
    input  up_start, up_read_addr, m_valid, m_data, m_last,
    output up_done, up_read_data, m_ready
  );
endinterface

// File: rtl/flatten_stream_reader.sv
// Reads the pooled feature map out of the upstream result memory byte by byte
// and re-emits it as a valid/ready stream through a small credit-managed FIFO.
module flatten_stream_reader #(
  parameter int N_BYTES    = 1600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  flatten_stream_reader_if.master bus
);

  localparam int CNT_W  = $clog2(N_BYTES + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_BYTES - 1);
  localparam logic [CNT_W-1:0]  N_CNT    = CNT_W'(N_BYTES);
  localparam logic [FCNT_W:0]   FIFO_LIM = (FCNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, UP_START, WAIT_UP, STREAM, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              inflight_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic              fifo_ne, credit_ok, issue, push, pop;
  logic [FCNT_W:0]   used;

  // A read is only issued when its returning byte is guaranteed a FIFO slot,
  // which is what lets the write side push without a full check.
  assign fifo_ne   = (fcnt_q != '0);
  assign used      = {1'b0, fcnt_q} + {{FCNT_W{1'b0}}, inflight_q};
  assign credit_ok = (used < FIFO_LIM);
  assign issue     = (state_q == STREAM) && credit_ok;
  assign push      = inflight_q;
  assign pop       = fifo_ne && bus.m_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    out_cnt_d = out_cnt_q;
    if (pop) out_cnt_d = out_cnt_q + CNT_W'(1);
    case (state_q)
      IDLE:     if (start) state_d = UP_START;
      UP_START: state_d = WAIT_UP;
      WAIT_UP: begin
        if (bus.up_done) begin
          addr_d    = '0;
          out_cnt_d = '0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (issue) begin
          // The address stops on the last index so it holds through DRAIN.
          if (addr_q == LAST_IDX) state_d = DRAIN;
          else                    addr_d  = addr_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (!fifo_ne && !inflight_q && (out_cnt_q == N_CNT)) state_d = DONE;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= issue;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fcnt_q     <= fcnt_q + FCNT_W'(push) - FCNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.up_read_data;
  end

  assign bus.m_valid      = fifo_ne;
  assign bus.m_data       = fifo_ne ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.m_last       = fifo_ne && (out_cnt_q == LAST_IDX);
  assign bus.up_start     = (state_q == UP_START);
  assign bus.up_read_addr = 32'(addr_q);
  assign busy             = (state_q == UP_START) || (state_q == WAIT_UP) ||
                            (state_q == STREAM)   || (state_q == DRAIN);
  assign done             = (state_q == DONE);

endmodule

// File: tb/tb_flatten_stream_reader.sv
// Directed bench for flatten_stream_reader: a full-size instance for the
// 1600-byte scenarios and a 5-byte/2-entry instance for the small-parameter case.
module tb_flatten_stream_reader;
  localparam int N = 1600;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic start  = 1'b0;
  logic start2 = 1'b0;
  logic busy, done, busy2, done2;

  flatten_stream_reader_if bus();
  flatten_stream_reader_if bus2();

  flatten_stream_reader #(.N_BYTES(N), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .bus(bus.master)
  );

  flatten_stream_reader #(.N_BYTES(5), .FIFO_DEPTH(2)) u_small (
    .clk(clk), .resetn(resetn), .start(start2), .busy(busy2), .done(done2), .bus(bus2.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Upstream result memory: byte k holds k mod 256, one-cycle read latency.
  always @(posedge clk) begin
    bus.up_read_data  <= bus.up_read_addr[7:0];
    bus2.up_read_data <= bus2.up_read_addr[7:0];
  end

  // Downstream ready: mode 0 always ready, mode 1 random with a 20-cycle stall.
  int rdy_mode = 0;
  int mode_prev = 0;
  int rctr = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode != mode_prev) rctr = 0;
    mode_prev = rdy_mode;
    rctr = rctr + 1;
    if (rdy_mode == 0) bus.m_ready = 1'b1;
    else bus.m_ready = (rctr >= 200 && rctr < 220) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  logic mon_clr = 1'b0;
  int n_bytes = 0, n_order_err = 0, n_last_hi = 0, n_last_bad = 0, n_stab_err = 0;
  int n_upstart = 0, n_done = 0, first_v_cyc = -1, first_hs = -1, last_hs = -1, max_fcnt = 0;
  logic stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_bytes = 0; n_order_err = 0; n_last_hi = 0; n_last_bad = 0; n_stab_err = 0;
      n_upstart = 0; n_done = 0; first_v_cyc = -1; first_hs = -1; last_hs = -1;
      max_fcnt = 0; stall_prev = 1'b0;
    end else begin
      if (stall_prev && (!bus.m_valid || bus.m_data !== data_prev)) n_stab_err++;
      if (bus.m_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (bus.m_last && !bus.m_valid) n_last_bad++;
      if (bus.m_valid && bus.m_ready) begin
        if (bus.m_data !== n_bytes[7:0]) n_order_err++;
        if (bus.m_last) n_last_hi++;
        if (bus.m_last !== (n_bytes == N - 1)) n_last_bad++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        n_bytes++;
      end
      if (bus.up_start) n_upstart++;
      if (done) n_done++;
      if (int'(u_dut.fcnt_q) > max_fcnt) max_fcnt = int'(u_dut.fcnt_q);
      stall_prev = bus.m_valid && !bus.m_ready;
      data_prev  = bus.m_data;
    end
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic do_run(input int extra_start_dly, output int c_ud,
                        output bit timed_out, output logic busy_seen);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    busy_seen = busy;
    repeat (48) @(posedge clk);
    #1 bus.up_done = 1'b1;
    c_ud = cyc;
    timed_out = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (i == 5) bus.up_done = 1'b0;
      start = (extra_start_dly != 0 && i == extra_start_dly);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    bus.up_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++; if (bus.up_start !== 1'b0) begin tests_failed++; $display("FAIL reset_up_start: got %b expected 0", bus.up_start); end
    tests_run++; if (bus.up_read_addr !== 32'd0) begin tests_failed++; $display("FAIL reset_addr: got %0d expected 0", bus.up_read_addr); end
    tests_run++; if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
    tests_run++; if (bus.m_last !== 1'b0) begin tests_failed++; $display("FAIL reset_m_last: got %b expected 0", bus.m_last); end
    tests_run++; if (bus.m_data !== 8'h00) begin tests_failed++; $display("FAIL reset_m_data: got %0h expected 0", bus.m_data); end
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests_run++; if (busy !== 1'b0 || bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset: busy %b m_valid %b expected 0 0", busy, bus.m_valid); end
  endtask

  task automatic test_basic();
    int c_ud; bit to; logic bs;
    rdy_mode = 0;
    clear_mon();
    do_run(0, c_ud, to, bs);
    tests_run++; if (to) begin tests_failed++; $display("FAIL basic_timeout: got timeout expected done"); end
    tests_run++; if (bs !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_after_start: got %b expected 1", bs); end
    tests_run++; if (n_bytes != N) begin tests_failed++; $display("FAIL basic_count: got %0d expected %0d", n_bytes, N); end
    tests_run++; if (n_order_err != 0) begin tests_failed++; $display("FAIL basic_order: got %0d errors expected 0", n_order_err); end
    tests_run++; if (n_last_hi != 1 || n_last_bad != 0) begin tests_failed++; $display("FAIL basic_last: got %0d/%0d expected 1/0", n_last_hi, n_last_bad); end
    tests_run++; if (n_done != 1) begin tests_failed++; $display("FAIL basic_done: got %0d expected 1", n_done); end
    tests_run++; if (n_upstart != 1) begin tests_failed++; $display("FAIL basic_up_start: got %0d expected 1", n_upstart); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    tests_run++; if (first_v_cyc != c_ud + 3) begin tests_failed++; $display("FAIL basic_first_valid: got %0d expected %0d", first_v_cyc, c_ud + 3); end
    tests_run++; if (last_hs - first_hs != N - 1) begin tests_failed++; $display("FAIL basic_throughput: got %0d expected %0d", last_hs - first_hs, N - 1); end
    tests_run++; if (bus.up_read_addr !== 32'd1599) begin tests_failed++; $display("FAIL basic_addr_hold: got %0d expected 1599", bus.up_read_addr); end
  endtask

  task automatic test_backpressure();
    int c_ud; bit to; logic bs;
    rdy_mode = 1;
    clear_mon();
    do_run(0, c_ud, to, bs);
    rdy_mode = 0;
    tests_run++; if (to) begin tests_failed++; $display("FAIL bp_timeout: got timeout expected done"); end
    tests_run++; if (n_bytes != N) begin tests_failed++; $display("FAIL bp_count: got %0d expected %0d", n_bytes, N); end
    tests_run++; if (n_order_err != 0) begin tests_failed++; $display("FAIL bp_order: got %0d errors expected 0", n_order_err); end
    tests_run++; if (n_stab_err != 0) begin tests_failed++; $display("FAIL bp_stable: got %0d errors expected 0", n_stab_err); end
    tests_run++; if (max_fcnt > 4) begin tests_failed++; $display("FAIL bp_fifo_max: got %0d expected <= 4", max_fcnt); end
    tests_run++; if (n_last_hi != 1 || n_last_bad != 0) begin tests_failed++; $display("FAIL bp_last: got %0d/%0d expected 1/0", n_last_hi, n_last_bad); end
  endtask

  task automatic test_start_while_busy();
    int c_ud; bit to; logic bs;
    rdy_mode = 0;
    clear_mon();
    do_run(300, c_ud, to, bs);
    repeat (10) @(posedge clk);
    #1;
    tests_run++; if (to) begin tests_failed++; $display("FAIL swb_timeout: got timeout expected done"); end
    tests_run++; if (n_upstart != 1) begin tests_failed++; $display("FAIL swb_up_start: got %0d expected 1", n_upstart); end
    tests_run++; if (n_bytes != N) begin tests_failed++; $display("FAIL swb_count: got %0d expected %0d", n_bytes, N); end
    tests_run++; if (n_done != 1) begin tests_failed++; $display("FAIL swb_done: got %0d expected 1", n_done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL swb_idle_after: got busy %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int c_ud; bit to; logic bs;
    bit reached;
    rdy_mode = 0;
    clear_mon();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (48) @(posedge clk);
    #1 bus.up_done = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (i == 5) bus.up_done = 1'b0;
      if (n_bytes >= 700) begin
        reached = 1'b1;
        break;
      end
    end
    bus.up_done = 1'b0;
    tests_run++; if (!reached) begin tests_failed++; $display("FAIL rst_mid_reach: got %0d bytes expected 700", n_bytes); end
    resetn = 1'b0;
    #1;
    tests_run++; if ({busy, done, bus.up_start, bus.m_valid, bus.m_last} !== 5'b0) begin tests_failed++; $display("FAIL rst_mid_ctrl: got %b expected 00000", {busy, done, bus.up_start, bus.m_valid, bus.m_last}); end
    tests_run++; if (bus.up_read_addr !== 32'd0) begin tests_failed++; $display("FAIL rst_mid_addr: got %0d expected 0", bus.up_read_addr); end
    tests_run++; if (bus.m_data !== 8'h00) begin tests_failed++; $display("FAIL rst_mid_data: got %0h expected 0", bus.m_data); end
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    clear_mon();
    repeat (20) @(posedge clk);
    #1;
    tests_run++; if (n_bytes != 0 || bus.m_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_quiet: got %0d bytes valid %b busy %b expected 0 0 0", n_bytes, bus.m_valid, busy); end
    clear_mon();
    do_run(0, c_ud, to, bs);
    tests_run++; if (to) begin tests_failed++; $display("FAIL rst_rerun_timeout: got timeout expected done"); end
    tests_run++; if (n_bytes != N) begin tests_failed++; $display("FAIL rst_rerun_count: got %0d expected %0d", n_bytes, N); end
    tests_run++; if (n_order_err != 0) begin tests_failed++; $display("FAIL rst_rerun_order: got %0d errors expected 0", n_order_err); end
  endtask

  task automatic test_small();
    int got;
    bit seen;
    bus2.m_ready = 1'b0;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus2.up_done = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus2.up_done = 1'b0;
    tests_run++; if (u_small.fcnt_q !== 2'd2) begin tests_failed++; $display("FAIL small_buffered: got %0d expected 2", u_small.fcnt_q); end
    tests_run++; if (bus2.up_read_addr !== 32'd2) begin tests_failed++; $display("FAIL small_issued: got next addr %0d expected 2", bus2.up_read_addr); end
    tests_run++; if (bus2.m_valid !== 1'b1 || bus2.m_data !== 8'h00) begin tests_failed++; $display("FAIL small_head: got valid %b data %0h expected 1 0", bus2.m_valid, bus2.m_data); end
    bus2.m_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus2.m_valid) begin
        tests_run++; if (bus2.m_data !== got[7:0]) begin tests_failed++; $display("FAIL small_data%0d: got %0h expected %0h", got, bus2.m_data, got[7:0]); end
        tests_run++; if (bus2.m_last !== (got == 4)) begin tests_failed++; $display("FAIL small_last%0d: got %b expected %b", got, bus2.m_last, (got == 4)); end
        got++;
        if (got == 5) break;
      end
    end
    tests_run++; if (got != 5) begin tests_failed++; $display("FAIL small_count: got %0d expected 5", got); end
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done2) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL small_done: got no pulse expected one"); end
    @(posedge clk); #1;
    tests_run++; if (busy2 !== 1'b0 || bus2.m_valid !== 1'b0) begin tests_failed++; $display("FAIL small_idle: got busy %b valid %b expected 0 0", busy2, bus2.m_valid); end
    bus2.m_ready = 1'b0;
  endtask

  initial begin
    bus.up_done   = 1'b0;
    bus2.up_done  = 1'b0;
    bus2.m_ready  = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_small();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, tests_failed %0d", tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
